// File: rtl/module_keypad_ctrl_pkg.sv
// Shared types and constants for the 4x4 keypad scan controller.
package pkg_keypad;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESENT  = 2'd2,
        RELEASE  = 2'd3
    } kp_state_t;

    localparam int KEY_W  = 4;
    localparam int N_ROWS = 4;
    localparam int N_COLS = 4;

    // Lowest-numbered active-low row wins when several rows are pressed.
    function automatic logic [1:0] first_low(input logic [N_ROWS-1:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = N_ROWS - 1; i >= 0; i--) begin
            if (!rows[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/module_keypad_ctrl_if.sv
// Key-code handshake between the keypad scanner and the operand-capture logic.
interface module_keypad_ctrl_if;
    import pkg_keypad::*;

    logic [KEY_W-1:0] key_code;
    logic             key_valid;
    logic             key_ready;

    modport master (output key_code, output key_valid, input key_ready);
    modport slave  (input key_code, input key_valid, output key_ready);
endinterface

// File: rtl/module_keypad_ctrl_sync.sv
// Parameterized two-flop synchronizer; resets to all ones to match idle pulled-up rows.
module module_sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] ff1_q;
    logic [WIDTH-1:0] ff2_q;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk) begin
        if (!rst) begin
            ff1_q <= '1;
            ff2_q <= '1;
        end else begin
            ff1_q <= d_i;
            ff2_q <= ff1_q;
        end
    end

    assign q_o = ff2_q;
endmodule

// File: rtl/module_keypad_ctrl.sv
// 4x4 keypad scanner: rotates column drive, debounces press and release,
// and hands the accepted key code over a valid/ready handshake.
module module_keypad_ctrl
    import pkg_keypad::*;
#(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 270000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_ROWS-1:0]   row_in,
    output logic [N_COLS-1:0]   col_out,
    output logic                scanning,
    module_keypad_ctrl_if.master kp
);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_ROWS-1:0] row_s;
    logic              any_low_s;
    logic              all_high_s;

    kp_state_t         state_q, state_d;
    logic [1:0]        col_q, col_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        row_idx_q, row_idx_d;
    logic [KEY_W-1:0]  code_q, code_d;
    logic              valid_q, valid_d;
    logic              scan_q, scan_d;
    logic [N_COLS-1:0] col_out_q, col_out_d;

    module_sync_2ff #(.WIDTH(N_ROWS)) u_row_sync (
        .clk (clk),
        .rst (rst),
        .d_i (row_in),
        .q_o (row_s)
    );

    assign any_low_s  = ~(&row_s);
    assign all_high_s = &row_s;

    // Next-state logic; a press seen in SCAN pre-empts a divider terminal count
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        div_d     = div_q;
        cnt_d     = cnt_q;
        row_idx_d = row_idx_q;
        code_d    = code_q;
        case (state_q)
            SCAN: begin
                if (any_low_s) begin
                    row_idx_d = first_low(row_s);
                    cnt_d     = '0;
                    state_d   = DEBOUNCE;
                end else if (div_q == DIV_LAST) begin
                    div_d = '0;
                    col_d = col_q + 2'd1;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            DEBOUNCE: begin
                if (row_s[row_idx_q]) begin
                    state_d = SCAN;
                end else if (cnt_q == CNT_LAST) begin
                    code_d  = {row_idx_q, col_q};
                    state_d = PRESENT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESENT: begin
                if (kp.key_ready) begin
                    cnt_d   = '0;
                    state_d = RELEASE;
                end else begin
                    state_d = PRESENT;
                end
            end
            RELEASE: begin
                if (!all_high_s) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    div_d   = '0;
                    col_d   = col_q + 2'd1;
                    state_d = SCAN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = SCAN;
            end
        endcase

        valid_d   = (state_d == PRESENT);
        scan_d    = (state_d == SCAN);
        col_out_d = ~(N_COLS'(1) << col_d);
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= SCAN;
            col_q     <= 2'd0;
            div_q     <= '0;
            cnt_q     <= '0;
            row_idx_q <= 2'd0;
            code_q    <= '0;
            valid_q   <= 1'b0;
            scan_q    <= 1'b1;
            col_out_q <= 4'b1110;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            row_idx_q <= row_idx_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            scan_q    <= scan_d;
            col_out_q <= col_out_d;
        end
    end

    assign col_out      = col_out_q;
    assign scanning     = scan_q;
    assign kp.key_code  = code_q;
    assign kp.key_valid = valid_q;
endmodule

// File: tb/tb_module_keypad_ctrl.sv
// Directed bench for the keypad scanner with SCAN_DIV=4, DEBOUNCE_CYCLES=8.
module tb_module_keypad_ctrl;
    logic       clk;
    logic       rst;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic       scanning;
    int         passed;
    int         total;

    module_keypad_ctrl_if kp_bus ();

    module_keypad_ctrl #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .row_in   (row_in),
        .col_out  (col_out),
        .scanning (scanning),
        .kp       (kp_bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // After this the reset edge R has just passed: col 0, divider 0.
    task automatic do_reset();
        rst    = 1'b0;
        row_in = 4'hF;
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        row_in = 4'hF;
        kp_bus.key_ready = 1'b0;
        tick();
        tick();
        total++; if (col_out !== 4'b1110) $display("FAIL reset_col: got %b expected 1110", col_out); else passed++;
        total++; if (kp_bus.key_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", kp_bus.key_valid); else passed++;
        total++; if (kp_bus.key_code !== 4'h0) $display("FAIL reset_code: got %h expected 0", kp_bus.key_code); else passed++;
        total++; if (scanning !== 1'b1) $display("FAIL reset_scanning: got %b expected 1", scanning); else passed++;
        rst = 1'b1;
    endtask

    task automatic test_scan_rotation();
        logic [3:0] exp_col;
        do_reset();
        for (int n = 0; n < 32; n++) begin
            exp_col = ~(4'b0001 << ((n / 4) % 4));
            total++; if (col_out !== exp_col) $display("FAIL scan_col n=%0d: got %b expected %b", n, col_out, exp_col); else passed++;
            total++; if (kp_bus.key_valid !== 1'b0) $display("FAIL scan_valid n=%0d: got %b expected 0", n, kp_bus.key_valid); else passed++;
            total++; if (scanning !== 1'b1) $display("FAIL scan_scanning n=%0d: got %b expected 1", n, scanning); else passed++;
            tick();
        end
    endtask

    task automatic test_clean_press();
        int         first_n;
        int         vcount;
        logic [3:0] code_seen;
        first_n   = -1;
        vcount    = 0;
        code_seen = 4'h0;
        kp_bus.key_ready = 1'b1;
        do_reset();
        for (int n = 1; n <= 34; n++) begin
            tick();
            if (n == 4)  row_in = 4'b1011;
            if (n == 20) row_in = 4'hF;
            if (kp_bus.key_valid === 1'b1) begin
                vcount++;
                if (first_n < 0) begin
                    first_n   = n;
                    code_seen = kp_bus.key_code;
                end
            end
            if (n == 6) begin
                total++; if (scanning !== 1'b1) $display("FAIL press_pre_exit: scanning=%b expected 1", scanning); else passed++;
            end
            if (n == 7) begin
                total++; if (scanning !== 1'b0) $display("FAIL press_exit: scanning=%b expected 0", scanning); else passed++;
                total++; if (col_out !== 4'b1101) $display("FAIL press_col_frozen: got %b expected 1101", col_out); else passed++;
            end
            if (n == 29) begin
                total++; if (scanning !== 1'b0) $display("FAIL release_hold: scanning=%b expected 0", scanning); else passed++;
            end
            if (n == 30) begin
                total++; if (scanning !== 1'b1) $display("FAIL release_done: scanning=%b expected 1", scanning); else passed++;
                total++; if (col_out !== 4'b1011) $display("FAIL release_col: got %b expected 1011", col_out); else passed++;
            end
        end
        total++; if (first_n !== 15) $display("FAIL press_latency: valid at cycle %0d expected 15", first_n); else passed++;
        total++; if (vcount !== 1) $display("FAIL press_pulses: got %0d expected 1", vcount); else passed++;
        total++; if (code_seen !== 4'b1001) $display("FAIL press_code: got %b expected 1001", code_seen); else passed++;
    endtask

    task automatic test_bounce();
        int vcount;
        vcount = 0;
        kp_bus.key_ready = 1'b0;
        do_reset();
        for (int n = 1; n <= 30; n++) begin
            tick();
            if (n == 12) row_in = 4'b1110;
            if (n == 17) row_in = 4'hF;
            if (kp_bus.key_valid === 1'b1) vcount++;
            if (n == 14) begin
                total++; if (scanning !== 1'b1) $display("FAIL bounce_pre: scanning=%b expected 1", scanning); else passed++;
            end
            if (n == 15 || n == 19) begin
                total++; if (scanning !== 1'b0) $display("FAIL bounce_debounce n=%0d: scanning=%b expected 0", n, scanning); else passed++;
            end
            if (n == 18 || n == 20 || n == 21) begin
                total++; if (col_out !== 4'b0111) $display("FAIL bounce_col n=%0d: got %b expected 0111", n, col_out); else passed++;
            end
            if (n == 20) begin
                total++; if (scanning !== 1'b1) $display("FAIL bounce_return: scanning=%b expected 1", scanning); else passed++;
            end
            if (n == 22) begin
                total++; if (col_out !== 4'b1110) $display("FAIL bounce_resume: got %b expected 1110", col_out); else passed++;
            end
        end
        total++; if (vcount !== 0) $display("FAIL bounce_valid: got %0d pulses expected 0", vcount); else passed++;
    endtask

    task automatic test_backpressure();
        int bad;
        bad = 0;
        kp_bus.key_ready = 1'b0;
        do_reset();
        row_in = 4'b0111;
        for (int n = 1; n <= 42; n++) begin
            tick();
            if (n == 15) row_in = 4'hF;
            if (n == 31) kp_bus.key_ready = 1'b1;
            if (n == 3) begin
                total++; if (scanning !== 1'b0) $display("FAIL bp_exit: scanning=%b expected 0", scanning); else passed++;
            end
            if (n == 10) begin
                total++; if (kp_bus.key_valid !== 1'b0) $display("FAIL bp_early: valid=%b expected 0", kp_bus.key_valid); else passed++;
            end
            if (n == 11) begin
                total++; if (kp_bus.key_valid !== 1'b1) $display("FAIL bp_rise: valid=%b expected 1", kp_bus.key_valid); else passed++;
                total++; if (kp_bus.key_code !== 4'b1100) $display("FAIL bp_code: got %b expected 1100", kp_bus.key_code); else passed++;
            end
            if (n >= 12 && n <= 31) begin
                if (kp_bus.key_valid !== 1'b1 || kp_bus.key_code !== 4'b1100) bad++;
            end
            if (n == 32) begin
                total++; if (kp_bus.key_valid !== 1'b0) $display("FAIL bp_fall: valid=%b expected 0", kp_bus.key_valid); else passed++;
            end
            if (n == 35) begin
                total++; if (kp_bus.key_code !== 4'b1100) $display("FAIL bp_code_hold: got %b expected 1100", kp_bus.key_code); else passed++;
            end
            if (n == 39) begin
                total++; if (scanning !== 1'b0) $display("FAIL bp_release_hold: scanning=%b expected 0", scanning); else passed++;
            end
            if (n == 40) begin
                total++; if (scanning !== 1'b1) $display("FAIL bp_release_done: scanning=%b expected 1", scanning); else passed++;
                total++; if (col_out !== 4'b1101) $display("FAIL bp_release_col: got %b expected 1101", col_out); else passed++;
            end
        end
        total++; if (bad !== 0) $display("FAIL bp_stable: %0d unstable cycles expected 0", bad); else passed++;
    endtask

    task automatic test_multi_row();
        kp_bus.key_ready = 1'b1;
        do_reset();
        for (int n = 1; n <= 22; n++) begin
            tick();
            if (n == 8) row_in = 4'b0101;
            if (n == 11) begin
                total++; if (scanning !== 1'b0) $display("FAIL multi_exit: scanning=%b expected 0", scanning); else passed++;
            end
            if (n == 18) begin
                total++; if (kp_bus.key_valid !== 1'b0) $display("FAIL multi_early: valid=%b expected 0", kp_bus.key_valid); else passed++;
            end
            if (n == 19) begin
                total++; if (kp_bus.key_valid !== 1'b1) $display("FAIL multi_valid: valid=%b expected 1", kp_bus.key_valid); else passed++;
                total++; if (kp_bus.key_code !== 4'b0110) $display("FAIL multi_code: got %b expected 0110", kp_bus.key_code); else passed++;
            end
            if (n == 20) begin
                total++; if (kp_bus.key_valid !== 1'b0) $display("FAIL multi_fall: valid=%b expected 0", kp_bus.key_valid); else passed++;
            end
            if (n == 21) begin
                total++; if (kp_bus.key_code !== 4'b0110) $display("FAIL multi_code_hold: got %b expected 0110", kp_bus.key_code); else passed++;
            end
        end
        row_in = 4'hF;
    endtask

    task automatic test_reset_mid_handshake();
        kp_bus.key_ready = 1'b0;
        do_reset();
        for (int n = 1; n <= 21; n++) begin
            tick();
            if (n == 8) row_in = 4'b0101;
            if (n == 19) begin
                total++; if (kp_bus.key_valid !== 1'b1) $display("FAIL mid_present: valid=%b expected 1", kp_bus.key_valid); else passed++;
            end
        end
        rst    = 1'b0;
        row_in = 4'hF;
        tick();
        rst = 1'b1;
        total++; if (kp_bus.key_valid !== 1'b0) $display("FAIL mid_valid: got %b expected 0", kp_bus.key_valid); else passed++;
        total++; if (col_out !== 4'b1110) $display("FAIL mid_col: got %b expected 1110", col_out); else passed++;
        total++; if (scanning !== 1'b1) $display("FAIL mid_scanning: got %b expected 1", scanning); else passed++;
        total++; if (kp_bus.key_code !== 4'h0) $display("FAIL mid_code: got %h expected 0", kp_bus.key_code); else passed++;
        kp_bus.key_ready = 1'b1;
        tick();
        tick();
        tick();
        total++; if (kp_bus.key_valid !== 1'b0) $display("FAIL mid_after: valid=%b expected 0", kp_bus.key_valid); else passed++;
        total++; if (col_out !== 4'b1110) $display("FAIL mid_after_col: got %b expected 1110", col_out); else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst    = 1'b0;
        row_in = 4'hF;
        kp_bus.key_ready = 1'b0;
        test_reset();
        test_scan_rotation();
        test_clean_press();
        test_bounce();
        test_backpressure();
        test_multi_row();
        test_reset_mid_handshake();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/module_keypad_ctrl.md
# module_keypad_ctrl

Scan controller for the 4x4 matrix keypad that feeds operands into the multiplier. It drives the columns in rotation from an internal 2-bit column counter and watches the rows. It debounces a detected press and presents a 4-bit key code to the operand-capture logic over a valid/ready handshake. It then waits for a debounced release before scanning resumes.

## Interface
Parameters:
- `SCAN_DIV`, default 1000: clock cycles each column is driven before the column counter advances; must be ≥ 2.
- `DEBOUNCE_CYCLES`, default 270000: consecutive stable cycles required to accept a press or a release; must be ≥ 1.

Ports:
- `clk`  in  1: system clock; the block has one clock.
- `rst`  in  1: reset, synchronous, active-low.
- `row_in`  in  4: keypad rows; active-low, pulled up externally; asynchronous to `clk`.
- `col_out`  out  4: column drive; exactly one bit low at all times.
- `key_code`  out  4: code of the accepted key, `{row_idx[1:0], col_idx[1:0]}`.
- `key_valid`  out  1: `key_code` is valid and held stable.
- `key_ready`  in  1: consumer accepts the code.
- `scanning`  out  1: high in state SCAN only.

## Operation
- **Input synchronizer:** `row_in` passes through a 2-flop synchronizer, giving `row_s`. A row counts as pressed when its `row_s` bit is 0.
- **Column drive:** `col_out = ~(4'b0001 << col_idx)`.
- **Press priority:** if several rows are pressed, the lowest row index wins.

State machine, four states:
- **SCAN:**
  - The divider counts `0..SCAN_DIV-1`. At terminal count, `col_idx` increments and wraps 3→0, and the divider clears.
  - If any `row_s` bit is 0, latch `row_idx`, hold `col_idx`, clear the debounce counter, and go to DEBOUNCE.
  - The press check takes priority over a divider terminal count in the same cycle, so the column does not advance.
- **DEBOUNCE:**
  - The column is frozen.
  - While the latched row stays 0, the debounce counter increments.
  - If the latched row reads 1 in any cycle, return to SCAN. `col_idx` and the divider continue from their held values.
  - When the counter reaches `DEBOUNCE_CYCLES-1` with the row still 0, load `key_code` and go to PRESENT.
- **PRESENT:**
  - `key_valid` is 1 and `key_code` is held.
  - On `key_valid && key_ready`, clear the debounce counter and go to RELEASE.
  - Release of the key while waiting does not drop `key_valid`; the code must still be delivered.
- **RELEASE:**
  - The column stays frozen.
  - The counter increments while all 4 `row_s` bits are 1 and clears whenever any bit is 0.
  - When the counter reaches `DEBOUNCE_CYCLES-1`, go to SCAN. The divider clears and `col_idx` advances by one.
- **Counter width:** the debounce counter is `$clog2(DEBOUNCE_CYCLES+1)` bits and the divider is `$clog2(SCAN_DIV)` bits. Neither counter may ever wrap.

## Timing
Reset (`rst`=0 at a `clk` edge) places the block in:
- state SCAN, `col_idx`=0, divider=0, debounce counter=0;
- `col_out`=4'b1110, `key_code`=4'h0, `key_valid`=0, `scanning`=1;
- synchronizer flops all 1.

Reset applies from any state, mid-debounce or mid-handshake included. A pending code is discarded.

Latency and handshake rules:
- **Press to SCAN exit:** a low row under the driven column leaves SCAN 3 cycles after the pin edge (2 synchronizer cycles plus 1 registered decision).
- **Press acceptance:** `key_valid` rises `DEBOUNCE_CYCLES` cycles after DEBOUNCE is entered.
- **Handshake:** `key_valid` falls on the cycle after the handshake cycle. `key_code` stays unchanged until the next acceptance.
- **Ready held early:** if `key_ready` is already held 1, the handshake completes on the first cycle of `key_valid`, so `key_valid` is high for exactly 1 cycle.
- **Register outputs:** all outputs are registered; `col_out`, `key_valid`, `key_code` and `scanning` have no combinational path from inputs.

## Structure
- **Package `pkg_keypad`:**
  - `typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESENT, RELEASE} kp_state_t`;
  - `localparam KEY_W = 4`;
  - `localparam N_ROWS = 4`, `localparam N_COLS = 4`.
- **Sub-module `module_sync_2ff`:** a parameterized-width 2-flop synchronizer. Its reset value is all 1s, using the same synchronous active-low reset.
- **Top level:** the column counter, divider, debounce counter and FSM live in `module_keypad_ctrl`.

## Test plan
Benches use `SCAN_DIV`=4, `DEBOUNCE_CYCLES`=8.
- **Reset and scan rotation:** reset, then no press for 32 cycles → `col_out` sequence 1110, 1101, 1011, 0111, 1110, each held 4 cycles; `key_valid`=0 throughout.
- **Clean press:** row 2 held low while col 1 is driven, with `key_ready`=1 → a single `key_valid` pulse with `key_code`=4'b1001. No second pulse until rows are high for 8 cycles.
- **Bounce rejection:** row 0 toggled low for 5 cycles then high, while col 3 is driven → return to SCAN, no `key_valid`, and scanning continues from col 3.
- **Backpressure:** press row 3 / col 0 with `key_ready`=0 for 20 cycles, releasing the key meanwhile → `key_valid` stays 1 and `key_code`=4'b1100 stays stable; `key_ready`=1 then completes the transfer.
- **Multi-row press:** rows 1 and 3 low under col 2 → `key_code`=4'b0110.
- **Reset mid-handshake:** `rst`=0 for 1 cycle during PRESENT → next cycle `key_valid`=0, `col_out`=1110, `scanning`=1.
